spi_eeprom_arbiter: RTL



---
 rtl/spi_eeprom_arbiter_pkg.sv | 27 ++
 rtl/spi_eeprom_arbiter_if.sv | 30 +++
 rtl/spi_eeprom_arbiter_bit_engine.sv | 85 ++++++++
 rtl/spi_eeprom_arbiter.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_eeprom_arbiter_pkg.sv
// Shared types and constants for the two-port SPI EEPROM read arbiter.
// Optional feature macro: SPI_ARB_BURST_LIMIT_EN (see spi_eeprom_arbiter.sv).
package spi_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CS_SETUP,
        ST_CMD,
        ST_ADDR,
        ST_DATA,
        ST_HOLD,
        ST_DESEL
    } arb_state_t;

    localparam logic [7:0] EEPROM_READ_CMD = 8'h03;
    localparam int         REQ_FETCH       = 0;
    localparam int         REQ_HOST        = 1;

    // Returns the index of the requester to grant; on a tie the one not served last wins.
    function automatic logic pick_grant(input logic [1:0] req, input logic last);
        if (req[REQ_FETCH] && req[REQ_HOST]) begin
            return ~last;
        end
        return req[REQ_HOST];
    endfunction

endpackage

// File: rtl/spi_eeprom_arbiter_if.sv
// Requester handshake plus EEPROM pin bundle. Valid/ready: a byte transfers on a cycle
// where rd_valid[g] and rd_ready[g] are both high; rd_data/rd_addr hold until then.
interface spi_eeprom_arbiter_if;
    import spi_arb_pkg::*;

    logic [1:0]  req;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [1:0]  gnt;
    logic [7:0]  rd_data;
    logic [1:0]  rd_valid;
    logic [1:0]  rd_ready;
    logic [15:0] rd_addr;
    logic        spi_cs_n;
    logic        spi_sck;
    logic        spi_copi;
    logic        spi_cipo;
    arb_state_t  dbg_state;

    modport master (
        output req, addr0, addr1, rd_ready, spi_cipo,
        input  gnt, rd_data, rd_valid, rd_addr, spi_cs_n, spi_sck, spi_copi, dbg_state
    );

    modport slave (
        input  req, addr0, addr1, rd_ready, spi_cipo,
        output gnt, rd_data, rd_valid, rd_addr, spi_cs_n, spi_sck, spi_copi, dbg_state
    );

endinterface

// File: rtl/spi_eeprom_arbiter_bit_engine.sv
// SPI mode-0 byte engine: SCK divider plus 8-bit shift register, MSB first.
// A stop request ends the byte at the end of the current SCK phase so SCK is left low.
module spi_bit_engine #(
    parameter int CLK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_tx_byte,
    input  logic       i_rx_en,
    input  logic       i_stop,
    input  logic       i_cipo,
    output logic       o_done,
    output logic [7:0] o_rx_byte,
    output logic       o_sck,
    output logic       o_copi
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic          r_busy;
    logic [DW-1:0] r_div;
    logic [2:0]    r_bit;
    logic [7:0]    r_tx;
    logic [7:0]    r_rx;
    logic          r_sck;
    logic          r_copi;
    logic          r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_div  <= '0;
            r_bit  <= 3'd0;
            r_tx   <= 8'h00;
            r_rx   <= 8'h00;
            r_sck  <= 1'b0;
            r_copi <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (!r_busy) begin
                if (i_start) begin
                    r_busy <= 1'b1;
                    r_div  <= '0;
                    r_bit  <= 3'd0;
                    r_sck  <= 1'b0;
                    r_copi <= i_tx_byte[7];
                    r_tx   <= {i_tx_byte[6:0], 1'b0};
                end
            end else if (i_stop && !r_sck) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
                r_copi <= 1'b0;
            end else if (r_div == DW'(CLK_DIV - 1)) begin
                r_div <= '0;
                if (!r_sck) begin
                    r_sck <= 1'b1;
                    if (i_rx_en) begin
                        r_rx <= {r_rx[6:0], i_cipo};
                    end
                end else begin
                    // Falling edge: COPI only moves here, while SCK goes low.
                    r_sck <= 1'b0;
                    if (r_bit == 3'd7 || i_stop) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_copi <= 1'b0;
                    end else begin
                        r_bit  <= r_bit + 3'd1;
                        r_copi <= r_tx[7];
                        r_tx   <= {r_tx[6:0], 1'b0};
                    end
                end
            end else begin
                r_div <= r_div + DW'(1);
            end
        end
    end

    assign o_done    = r_done;
    assign o_rx_byte = r_rx;
    assign o_sck     = r_sck;
    assign o_copi    = r_copi;

endmodule

// File: rtl/spi_eeprom_arbiter.sv
// Two-port round-robin arbiter issuing EEPROM READ bursts and streaming bytes back.
// Optional macro SPI_ARB_BURST_LIMIT_EN caps a grant at MAX_BURST bytes when the other port waits.
module spi_eeprom_arbiter
    import spi_arb_pkg::*;
#(
    parameter int CLK_DIV     = 1,
    parameter int ADDR_BYTES  = 2,
    parameter int CS_HIGH_CYC = 2
`ifdef SPI_ARB_BURST_LIMIT_EN
    ,
    parameter int MAX_BURST   = 16
`endif
) (
    input logic                 clk,
    input logic                 rst_n,
    spi_eeprom_arbiter_if.slave bus
);
    localparam int CW = 16;

    arb_state_t  r_state;
    logic        r_g;
    logic [1:0]  r_gnt;
    logic        r_last;
    logic [15:0] r_addr;
    logic [15:0] r_rd_addr;
    logic [7:0]  r_rd_data;
    logic [1:0]  r_rd_valid;
    logic        r_cs_n;
    logic [7:0]  r_tx;
    logic        r_start;
    logic        r_stop;
    logic        r_abort;
    logic        r_rx_en;
    logic [CW-1:0] r_cnt;

    logic        w_req_g;
    logic        w_pick;
    logic        w_done;
    logic        w_limit;
    logic [7:0]  w_rx_byte;
    logic        w_sck;
    logic        w_copi;

    // The EEPROM's internal address counter wraps at its address width.
    function automatic logic [15:0] wrap_addr(input logic [15:0] a);
        return (ADDR_BYTES == 1) ? {8'h00, a[7:0]} : a;
    endfunction

    assign w_req_g = bus.req[r_g];
    assign w_pick  = pick_grant(bus.req, r_last);

`ifdef SPI_ARB_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST + 1);
    logic [BW-1:0] r_burst;
    assign w_limit = (r_burst == BW'(MAX_BURST - 1)) && bus.req[~r_g];
`else
    assign w_limit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_g        <= 1'b0;
            r_gnt      <= 2'b00;
            r_last     <= 1'(REQ_HOST);
            r_addr     <= 16'h0000;
            r_rd_addr  <= 16'h0000;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 2'b00;
            r_cs_n     <= 1'b1;
            r_tx       <= 8'h00;
            r_start    <= 1'b0;
            r_stop     <= 1'b0;
            r_abort    <= 1'b0;
            r_rx_en    <= 1'b0;
            r_cnt      <= '0;
`ifdef SPI_ARB_BURST_LIMIT_EN
            r_burst    <= '0;
`endif
        end else begin
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_g       <= w_pick;
                        r_gnt     <= w_pick ? 2'b10 : 2'b01;
                        r_addr    <= w_pick ? bus.addr1 : bus.addr0;
                        r_rd_addr <= wrap_addr(w_pick ? bus.addr1 : bus.addr0);
                        r_cs_n    <= 1'b0;
                        r_cnt     <= '0;
                        r_abort   <= 1'b0;
                        r_stop    <= 1'b0;
                        r_rx_en   <= 1'b0;
`ifdef SPI_ARB_BURST_LIMIT_EN
                        r_burst   <= '0;
`endif
                        r_state   <= ST_CS_SETUP;
                    end
                end
                ST_CS_SETUP: begin
                    if (!w_req_g) begin
                        r_cs_n  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_DESEL;
                    end else if (r_cnt == CW'(CLK_DIV - 1)) begin
                        r_tx    <= EEPROM_READ_CMD;
                        r_start <= 1'b1;
                        r_state <= ST_CMD;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_CMD, ST_ADDR, ST_DATA: begin
                    if (w_done) begin
                        if (r_abort || !w_req_g) begin
                            // Partial or unwanted byte is dropped; SCK is already low.
                            r_stop  <= 1'b0;
                            r_cs_n  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_DESEL;
                        end else if (r_state == ST_CMD) begin
                            r_tx    <= (ADDR_BYTES == 2) ? r_addr[15:8] : r_addr[7:0];
                            r_cnt   <= CW'(ADDR_BYTES - 1);
                            r_start <= 1'b1;
                            r_state <= ST_ADDR;
                        end else if (r_state == ST_ADDR) begin
                            if (r_cnt == '0) begin
                                r_tx    <= 8'h00;
                                r_rx_en <= 1'b1;
                                r_start <= 1'b1;
                                r_state <= ST_DATA;
                            end else begin
                                r_tx    <= r_addr[7:0];
                                r_cnt   <= r_cnt - CW'(1);
                                r_start <= 1'b1;
                            end
                        end else begin
                            r_rd_data  <= w_rx_byte;
                            r_rd_valid <= r_gnt;
                            r_state    <= ST_HOLD;
                        end
                    end else if (!w_req_g) begin
                        r_abort <= 1'b1;
                        r_stop  <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.rd_ready[r_g]) begin
                        r_rd_valid <= 2'b00;
`ifdef SPI_ARB_BURST_LIMIT_EN
                        r_burst    <= r_burst + BW'(1);
`endif
                        if (w_req_g && !w_limit) begin
                            r_rd_addr <= wrap_addr(r_rd_addr + 16'd1);
                            r_tx      <= 8'h00;
                            r_start   <= 1'b1;
                            r_state   <= ST_DATA;
                        end else begin
                            r_cs_n  <= 1'b1;
                            r_cnt   <= '0;
                            r_state <= ST_DESEL;
                        end
                    end
                end
                ST_DESEL: begin
                    if (r_cnt == CW'(CS_HIGH_CYC - 1)) begin
                        r_gnt   <= 2'b00;
                        r_last  <= r_g;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    spi_bit_engine #(
        .CLK_DIV(CLK_DIV)
    ) u_engine (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (r_start),
        .i_tx_byte(r_tx),
        .i_rx_en  (r_rx_en),
        .i_stop   (r_stop),
        .i_cipo   (bus.spi_cipo),
        .o_done   (w_done),
        .o_rx_byte(w_rx_byte),
        .o_sck    (w_sck),
        .o_copi   (w_copi)
    );

    assign bus.gnt       = r_gnt;
    assign bus.rd_data   = r_rd_data;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.spi_cs_n  = r_cs_n;
    assign bus.spi_sck   = w_sck;
    assign bus.spi_copi  = w_copi;
    assign bus.dbg_state = r_state;

endmodule
